// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder family:
// default widths, pipeline depth helper and operation mode encoding.
package cla_pkg;

  localparam int DATA_WID_DEF  = 32;
  localparam int GROUP_WID_DEF = 8;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int num_groups(input int data_wid, input int group_wid);
    return data_wid / group_wid;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP_WID-bit carry-lookahead block: per-bit generate and
// propagate, sum-of-products carries, group G/P and carry into the MSB.
module cla_group #(
  parameter int GROUP_WID = 8
) (
  input  logic [GROUP_WID-1:0] a,
  input  logic [GROUP_WID-1:0] b,
  input  logic                 cin,
  output logic [GROUP_WID-1:0] s,
  output logic                 cout,
  output logic                 c_msb
);

  logic [GROUP_WID-1:0] g_s;
  logic [GROUP_WID-1:0] p_s;
  logic [GROUP_WID:0]   c_s;
  logic                 gen_s;
  logic                 prod_s;
  logic                 grp_g_s;
  logic                 grp_p_s;

  // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (p[0..i] & cin).
  always_comb begin
    g_s     = a & b;
    p_s     = a ^ b;
    c_s     = '0;
    c_s[0]  = cin;
    gen_s   = 1'b0;
    prod_s  = 1'b1;
    for (int i = 0; i < GROUP_WID; i++) begin
      gen_s  = 1'b0;
      prod_s = 1'b1;
      for (int j = i; j >= 0; j--) begin
        gen_s  = gen_s | (g_s[j] & prod_s);
        prod_s = prod_s & p_s[j];
      end
      c_s[i+1] = gen_s | (prod_s & cin);
    end
    grp_g_s = gen_s;
    grp_p_s = prod_s;
  end

  assign s     = p_s ^ c_s[GROUP_WID-1:0];
  assign cout  = grp_g_s | (grp_p_s & cin);
  assign c_msb = c_s[GROUP_WID-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one register stage per lookahead group,
// group carry handed stage to stage, valid/ready handshake on both sides.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int DATA_WID  = DATA_WID_DEF,
  parameter int GROUP_WID = GROUP_WID_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  input  logic                carry_in,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int NUM_GROUPS = num_groups(DATA_WID, GROUP_WID);

  if (((DATA_WID % GROUP_WID) != 0) || (DATA_WID < GROUP_WID)) begin : g_bad_width
    $error("DATA_WID must be a non-zero multiple of GROUP_WID");
  end

  logic                                 advance_s;
  logic [DATA_WID-1:0]                  b_eff_s;
  logic                                 cin_eff_s;

  logic [NUM_GROUPS-1:0][GROUP_WID-1:0] grp_a_s;
  logic [NUM_GROUPS-1:0][GROUP_WID-1:0] grp_b_s;
  logic [NUM_GROUPS-1:0][GROUP_WID-1:0] grp_s_s;
  logic [NUM_GROUPS-1:0]                grp_cin_s;
  logic [NUM_GROUPS-1:0]                grp_cout_s;
  logic [NUM_GROUPS-1:0]                grp_cmsb_s;

  logic [NUM_GROUPS-1:0][DATA_WID-1:0]  a_d, a_q;
  logic [NUM_GROUPS-1:0][DATA_WID-1:0]  b_d, b_q;
  logic [NUM_GROUPS-1:0][DATA_WID-1:0]  s_d, s_q;
  logic [NUM_GROUPS-1:0]                c_d, c_q;
  logic [NUM_GROUPS-1:0]                v_d, v_q;
  logic                                 ov_d, ov_q;

  // Operand conditioning and global pipeline advance.
  always_comb begin
    if (sub == MODE_SUB) begin
      b_eff_s   = ~in2;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = in2;
      cin_eff_s = carry_in;
    end
    advance_s = out_ready || !v_q[NUM_GROUPS-1];
  end

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stage
    localparam logic [DATA_WID-1:0] SLICE_MASK =
      ({DATA_WID{1'b1}} >> (DATA_WID - GROUP_WID)) << (k * GROUP_WID);

    if (k == 0) begin : g_first
      assign grp_a_s[k]   = in1[GROUP_WID-1:0];
      assign grp_b_s[k]   = b_eff_s[GROUP_WID-1:0];
      assign grp_cin_s[k] = cin_eff_s;
      assign a_d[k]       = in1;
      assign b_d[k]       = b_eff_s;
      assign s_d[k]       = DATA_WID'(grp_s_s[k]);
      assign v_d[k]       = in_valid && advance_s;
    end else begin : g_next
      assign grp_a_s[k]   = a_q[k-1][k*GROUP_WID +: GROUP_WID];
      assign grp_b_s[k]   = b_q[k-1][k*GROUP_WID +: GROUP_WID];
      assign grp_cin_s[k] = c_q[k-1];
      assign a_d[k]       = a_q[k-1];
      assign b_d[k]       = b_q[k-1];
      assign s_d[k]       = (s_q[k-1] & ~SLICE_MASK) |
                            (DATA_WID'(grp_s_s[k]) << (k * GROUP_WID));
      assign v_d[k]       = v_q[k-1];
    end

    assign c_d[k] = grp_cout_s[k];

    cla_group #(
      .GROUP_WID (GROUP_WID)
    ) u_group (
      .a     (grp_a_s[k]),
      .b     (grp_b_s[k]),
      .cin   (grp_cin_s[k]),
      .s     (grp_s_s[k]),
      .cout  (grp_cout_s[k]),
      .c_msb (grp_cmsb_s[k])
    );
  end

  assign ov_d = grp_cmsb_s[NUM_GROUPS-1] ^ grp_cout_s[NUM_GROUPS-1];

  // Operand copies in the last stage and non-final MSB carries feed nothing.
  logic unused_s;
  assign unused_s = ^{a_q[NUM_GROUPS-1], b_q[NUM_GROUPS-1], grp_cmsb_s};

  // Pipeline state: every stage, valids included, moves together on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      c_q  <= '0;
      v_q  <= '0;
      ov_q <= 1'b0;
    end else if (advance_s) begin
      a_q  <= a_d;
      b_q  <= b_d;
      s_q  <= s_d;
      c_q  <= c_d;
      v_q  <= v_d;
      ov_q <= ov_d;
    end
  end

  assign in_ready  = advance_s;
  assign out_valid = v_q[NUM_GROUPS-1];
  assign sum       = s_q[NUM_GROUPS-1];
  assign carry_out = c_q[NUM_GROUPS-1];
  assign overflow  = ov_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed vectors push expected
// results, an independent monitor pops and compares on every delivery.
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  localparam int DW = 32;
  localparam int NG = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, carry_in, sub;
  logic [DW-1:0] in1, in2, sum;
  logic          out_valid, out_ready, carry_out, overflow;

  logic          d_in_valid, d_in_ready, d_carry_in, d_sub;
  logic [DW-1:0] d_in1, d_in2, d_sum;
  logic          d_out_valid, d_out_ready, d_carry_out, d_overflow;

  typedef struct {
    logic [DW-1:0] s;
    logic          c;
    logic          o;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t sb_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   edge_cnt = 0;
  int   bp_lo    = 0;
  int   bp_hi    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  pipelined_cla_adder #(.DATA_WID(DW), .GROUP_WID(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  pipelined_cla_adder #(.DATA_WID(DW), .GROUP_WID(32)) dut_deg (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in1(d_in1), .in2(d_in2), .carry_in(d_carry_in), .sub(d_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .sum(d_sum),
    .carry_out(d_carry_out), .overflow(d_overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle_begin();
    @(negedge clk);
    out_ready = !((edge_cnt >= bp_lo) && (edge_cnt < bp_hi));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cycle_begin();
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                      input logic sb, input logic [DW-1:0] es, input logic ec,
                      input logic eo, input bit lat);
    int   tries;
    exp_t e;
    tries = 0;
    cycle_begin();
    in_valid = 1'b1; in1 = a; in2 = b; carry_in = cin; sub = sb;
    #1;
    while (!in_ready && tries < 50) begin
      cycle_begin();
      #1;
      tries++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", tries);
    end else begin
      e.s = es; e.c = ec; e.o = eo; e.acc = edge_cnt + 1; e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
  endtask

  // Monitor: handshake rule, output hold under stall, in-order results.
  initial begin : monitor
    exp_t          e;
    logic          held_v;
    logic [DW+1:0] held;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (held_v && out_valid)
          check("hold", 64'({sum, carry_out, overflow}), 64'(held));
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum %0h with no beat outstanding", sum);
          end else begin
            e = sb_q.pop_front();
            check("sum", 64'(sum), 64'(e.s));
            check("carry_out", 64'(carry_out), 64'(e.c));
            check("overflow", 64'(overflow), 64'(e.o));
            if (e.lat) check("latency", 64'(edge_cnt - e.acc), 64'(NG - 1));
          end
        end
        held_v = out_valid && !out_ready;
        held   = {sum, carry_out, overflow};
      end
    end
  end

  initial begin : main
    int s0;
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; carry_in = 1'b0; sub = MODE_ADD;
    out_ready = 1'b1;
    d_in_valid = 1'b0; d_in1 = '0; d_in2 = '0; d_carry_in = 1'b0; d_sub = MODE_ADD;
    d_out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_carry_out", 64'(carry_out), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Carry ripple, signed overflow, subtract (carry_in ignored in subtract).
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    idle(6);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, MODE_ADD, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, MODE_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0007, 32'h0000_0005, 1'b1, MODE_SUB, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, MODE_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    idle(8);

    // Streaming with out_ready low for cycles 6..9 of the burst.
    s0 = edge_cnt;
    bp_lo = s0 + 6;
    bp_hi = s0 + 10;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, MODE_ADD, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0010, 32'h0000_0001, 1'b0, MODE_SUB, 32'h0000_000F, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, MODE_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    send(32'h0000_0000, 32'h0000_0001, 1'b0, MODE_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    send(32'h1234_5678, 32'h1111_1111, 1'b1, MODE_ADD, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, MODE_SUB, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, MODE_SUB, 32'h5555_5555, 1'b1, 1'b1, 1'b0);
    send(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, MODE_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(32'h0000_0064, 32'h0000_0064, 1'b0, MODE_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    idle(12);
    bp_lo = 0;
    bp_hi = 0;
    check("stream_drained", 64'(sb_q.size()), 64'(0));

    // Reset with the first result on the output and three beats behind it.
    send(32'h1111_1111, 32'h2222_2222, 1'b0, MODE_ADD, 32'h3333_3333, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0001, 32'h0000_0001, 1'b0, MODE_ADD, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0002, 32'h0000_0002, 1'b0, MODE_ADD, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0003, 32'h0000_0003, 1'b0, MODE_ADD, 32'h0000_0006, 1'b0, 1'b0, 1'b1);
    #1;
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    sb_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h0000_1000, 32'h0000_0234, 1'b0, MODE_ADD, 32'h0000_1234, 1'b0, 1'b0, 1'b1);
    idle(10);
    check("post_rst_drained", 64'(sb_q.size()), 64'(0));

    // Single-group configuration: one-cycle latency.
    @(negedge clk);
    d_in_valid = 1'b1; d_in1 = 32'd10; d_in2 = 32'd20; d_sub = MODE_ADD;
    #1;
    check("deg_pre_valid", 64'(d_out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("deg_valid", 64'(d_out_valid), 64'(1));
    check("deg_sum", 64'(d_sum), 64'(30));
    check("deg_carry_out", 64'(d_carry_out), 64'(0));
    d_in1 = 32'd10; d_in2 = 32'd20; d_sub = MODE_SUB;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    check("deg_sub_sum", 64'(d_sum), 64'(32'hFFFF_FFF6));
    check("deg_sub_carry_out", 64'(d_carry_out), 64'(0));
    @(posedge clk);
    #1;
    check("deg_bubble", 64'(d_out_valid), 64'(0));

    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
